nbbpu_run_monitor: RTL

Synthesisable run-control and trace monitor for the NBBPU core. It replaces the fixed 24-cycle stop counter used in bench code with a parametrised unit that:
- starts and stops core execution,
- stops on a cycle limit, a halt loop or a PC breakpoint,
- keeps a circular history of recent (PC, instruction) pairs for readout.

It sits beside nbbpu and rom, observes the core bus, and is used in simulation and on FPGA builds.

---
 rtl/nbbpu_run_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/nbbpu_run_monitor.sv
// nbbpu_run_monitor: run control and trace history for the NBBPU core.
// Starts the core on a start pulse and stops it on a cycle limit, a halt
// loop (PC unchanged for HALT_REPEAT cycles) or a PC breakpoint. While
// running, every cycle's {pc, instruction} is captured into a circular
// history FIFO that keeps the most recent TRACE_DEPTH entries.
// Optional feature macro: NBBPU_RUN_MONITOR_WRITE_COUNT_EN adds write_count,
// a saturating count of data-write strobes seen during RUN.
module nbbpu_run_monitor #(
  parameter int WIDTH       = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_CYCLES  = 24,
  parameter int HALT_REPEAT = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [WIDTH-1:0]               pc,
  input  logic [WIDTH-1:0]               instruction,
  input  logic                           data_write,
  input  logic [WIDTH-1:0]               breakpoint_address,
  input  logic                           breakpoint_enable,
  output logic                           core_run,
  output logic                           done,
  output logic [1:0]                     done_cause,
  output logic [COUNT_WIDTH-1:0]         cycle_count,
  input  logic                           trace_read,
  output logic                           trace_valid,
  output logic [WIDTH-1:0]               trace_pc,
  output logic [WIDTH-1:0]               trace_instruction,
  output logic [$clog2(TRACE_DEPTH):0]   trace_level,
  output logic                           trace_overflow
`ifdef NBBPU_RUN_MONITOR_WRITE_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]         write_count
`endif
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int HW = $clog2(HALT_REPEAT + 1);
  localparam logic [COUNT_WIDTH-1:0] CYC_LIMIT  = COUNT_WIDTH'(MAX_CYCLES);
  localparam logic [HW-1:0]          HALT_LIMIT = HW'(HALT_REPEAT);
  localparam logic [AW:0]            FIFO_FULL  = (AW + 1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOPPED} state_t;

  state_t state, state_next;

  logic [HW-1:0]          halt_cnt;
  logic [WIDTH-1:0]       prev_pc;
  logic [COUNT_WIDTH-1:0] cycle_inc;
  logic [HW-1:0]          halt_inc;
  logic                   hit_break, hit_halt, hit_limit, stop;
  logic [1:0]             cause_sel;

  logic [WIDTH-1:0] mem_pc    [TRACE_DEPTH];
  logic [WIDTH-1:0] mem_instr [TRACE_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, full;

  function automatic logic [COUNT_WIDTH-1:0] sat_cycle(input logic [COUNT_WIDTH-1:0] v);
    return (v >= CYC_LIMIT) ? CYC_LIMIT : v + 1'b1;
  endfunction

  function automatic logic [HW-1:0] sat_halt(input logic [HW-1:0] v);
    return (v >= HALT_LIMIT) ? HALT_LIMIT : v + 1'b1;
  endfunction

  // Stop detection on this cycle's inputs and the post-increment counters
  always_comb begin
    cycle_inc = sat_cycle(cycle_count);
    halt_inc  = (pc == prev_pc) ? sat_halt(halt_cnt) : '0;
    hit_break = breakpoint_enable && (pc == breakpoint_address);
    hit_halt  = (halt_inc == HALT_LIMIT);
    hit_limit = (cycle_inc == CYC_LIMIT);
    stop      = hit_break || hit_halt || hit_limit;
    cause_sel = hit_break ? 2'd3 : (hit_halt ? 2'd2 : 2'd1);
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> STOPPED on any stop, STOPPED holds
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop)  state_next = STOPPED;
      STOPPED: state_next = STOPPED;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Registered run outputs, counters and previous-PC tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      core_run    <= 1'b0;
      done        <= 1'b0;
      done_cause  <= 2'd0;
      cycle_count <= '0;
      halt_cnt    <= '0;
      prev_pc     <= '0;
    end else begin
      core_run <= (state_next == RUN);
      done     <= (state_next == STOPPED);
      if (state == IDLE && start) begin
        cycle_count <= '0;
        halt_cnt    <= '0;
      end else if (state == RUN) begin
        cycle_count <= cycle_inc;
        halt_cnt    <= halt_inc;
        prev_pc     <= pc;
        if (stop) done_cause <= cause_sel;
      end
    end
  end

  assign push        = (state == RUN);
  assign trace_valid = (trace_level != '0);
  assign pop         = trace_read && trace_valid;
  assign full        = (trace_level == FIFO_FULL);

  // Trace storage; data only, so no reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= instruction;
    end
  end

  // Trace pointers: a push into a full FIFO without a pop drops the oldest entry
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_level    <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) trace_overflow <= 1'b1;
      if (push && !pop && !full) trace_level <= trace_level + 1'b1;
      else if (pop && !push)     trace_level <= trace_level - 1'b1;
    end
  end

  assign trace_pc          = mem_pc[rd_ptr];
  assign trace_instruction = mem_instr[rd_ptr];

`ifdef NBBPU_RUN_MONITOR_WRITE_COUNT_EN
  function automatic logic [COUNT_WIDTH-1:0] sat_all_ones(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Data-write strobes counted only while running; frozen once stopped
  always_ff @(posedge clock) begin
    if (reset)                          write_count <= '0;
    else if (state == IDLE && start)    write_count <= '0;
    else if (state == RUN && data_write) write_count <= sat_all_ones(write_count);
  end
`else
  logic unused_data_write;
  assign unused_data_write = data_write;
`endif

endmodule
